// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game controller.
// The optional WAIT-state input timeout is enabled by defining SIMON_TIMEOUT_EN.
package simon_pkg;

    // Widest channel count the controller supports; onehot() is sized to it.
    localparam int MAX_CH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHOW  = 3'd1,
        GAP   = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        ERROR = 3'd5,
        WIN   = 3'd6
    } state_t;

    // One-hot decode of a channel index; callers keep the low NUM_CH bits.
    function automatic logic [MAX_CH-1:0] onehot(input logic [2:0] idx);
        logic [MAX_CH-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// Player/memory-facing signal bundle of the Simon game controller.
// master: the controller; slave: the surrounding board (memory, buttons, LEDs).
interface simon_game_ctrl_if #(
    parameter int NUM_CH  = 4,
    parameter int MAX_LEN = 16
);
    localparam int CW = $clog2(NUM_CH);
    localparam int AW = $clog2(MAX_LEN);
    localparam int SW = $clog2(MAX_LEN + 1);

    logic              start_play;
    logic [CW-1:0]     seq_val;
    logic              btn_valid;
    logic [CW-1:0]     btn_val;
    logic [AW-1:0]     rd_addr;
    logic [NUM_CH-1:0] led;
    logic              error_led;
    logic              win_led;
    logic [SW-1:0]     score;

    modport master (
        input  start_play, seq_val, btn_valid, btn_val,
        output rd_addr, led, error_led, win_led, score
    );

    modport slave (
        output start_play, seq_val, btn_valid, btn_val,
        input  rd_addr, led, error_led, win_led, score
    );

endinterface

// File: rtl/simon_timeout_ctr.sv
// Tick counter that flags when the player has been idle for TIMEOUT_TICKS
// ticks in WAIT. Only instantiated when SIMON_TIMEOUT_EN is defined.
module simon_timeout_ctr #(
    parameter int TIMEOUT_TICKS = 8
) (
    input  logic clk_tick,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    assign expired = (count == 8'(TIMEOUT_TICKS - 1));

    // Count idle ticks; hold at the terminal value so it never wraps.
    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk_tick) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon game controller: plays back a growing sequence from an external
// memory, then checks the player's presses against it round by round.
// Define SIMON_TIMEOUT_EN to send an idle player in WAIT to ERROR.
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_TICKS = 8
) (
    input logic               clk_tick,
    input logic               reset,
    simon_game_ctrl_if.master bus
);

    localparam int CW = $clog2(NUM_CH);
    localparam int AW = $clog2(MAX_LEN);
    localparam int SW = $clog2(MAX_LEN + 1);

    // Reject illegal configurations at elaboration time.
    if (!(NUM_CH == 2 || NUM_CH == 4 || NUM_CH == 8)) begin : g_bad_num_ch
        $error("simon_game_ctrl: NUM_CH must be 2, 4 or 8");
    end
    if (MAX_LEN < 2 || MAX_LEN > 256) begin : g_bad_max_len
        $error("simon_game_ctrl: MAX_LEN must be in 2..256");
    end
    if (TIMEOUT_TICKS < 2 || TIMEOUT_TICKS > 255) begin : g_bad_timeout
        $error("simon_game_ctrl: TIMEOUT_TICKS must be in 2..255");
    end

    state_t        state, state_d;
    logic [SW-1:0] round_cnt, round_d;
    logic [SW-1:0] score_q, score_d;
    logic [AW-1:0] play_idx, play_d;
    logic [AW-1:0] input_idx, input_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0] btn_lat, btn_lat_d;

`ifdef SIMON_TIMEOUT_EN
    logic timer_clear;
    logic timer_expired;

    // Every entry into WAIT comes from GAP or CHECK, so clearing outside WAIT
    // restarts the idle count from zero on each new expected press.
    assign timer_clear = (state != WAIT);

    simon_timeout_ctr #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk_tick (clk_tick),
        .reset    (reset),
        .clear    (timer_clear),
        .enable   (state == WAIT && !bus.btn_valid),
        .expired  (timer_expired)
    );
`endif

    // Next-state and next-counter logic for the game sequencer.
    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state;
        round_d   = round_cnt;
        score_d   = score_q;
        play_d    = play_idx;
        input_d   = input_idx;
        rd_addr_d = rd_addr_q;
        btn_lat_d = btn_lat;

        case (state)
            IDLE: begin
                if (bus.start_play) begin
                    round_d   = SW'(1);
                    play_d    = '0;
                    rd_addr_d = '0;
                    score_d   = '0;
                    state_d   = SHOW;
                end
            end

            SHOW: state_d = GAP;

            GAP: begin
                if (SW'(play_idx) + SW'(1) == round_cnt) begin
                    input_d   = '0;
                    rd_addr_d = '0;
                    state_d   = WAIT;
                end else begin
                    play_d    = play_idx + AW'(1);
                    rd_addr_d = play_idx + AW'(1);
                    state_d   = SHOW;
                end
            end

            WAIT: begin
                if (bus.btn_valid) begin
                    btn_lat_d = bus.btn_val;
                    state_d   = CHECK;
                end
`ifdef SIMON_TIMEOUT_EN
                else if (timer_expired) begin
                    state_d = ERROR;
                end
`endif
            end

            CHECK: begin
                if (btn_lat != bus.seq_val) begin
                    state_d = ERROR;
                end else if (SW'(input_idx) + SW'(1) == round_cnt) begin
                    score_d = round_cnt;
                    if (round_cnt == SW'(MAX_LEN)) begin
                        state_d = WIN;
                    end else begin
                        round_d   = round_cnt + SW'(1);
                        play_d    = '0;
                        rd_addr_d = '0;
                        state_d   = SHOW;
                    end
                end else begin
                    input_d   = input_idx + AW'(1);
                    rd_addr_d = input_idx + AW'(1);
                    state_d   = WAIT;
                end
            end

            ERROR: begin
                if (bus.btn_valid) begin
                    round_d   = SW'(1);
                    play_d    = '0;
                    rd_addr_d = '0;
                    score_d   = '0;
                    state_d   = SHOW;
                end
            end

            WIN: begin
                if (bus.btn_valid) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; reset discards all game progress.
    always_ff @(posedge clk_tick) begin
        if (reset) begin
            state     <= IDLE;
            round_cnt <= '0;
            score_q   <= '0;
            play_idx  <= '0;
            input_idx <= '0;
            rd_addr_q <= '0;
            btn_lat   <= '0;
        end else begin
            state     <= state_d;
            round_cnt <= round_d;
            score_q   <= score_d;
            play_idx  <= play_d;
            input_idx <= input_d;
            rd_addr_q <= rd_addr_d;
            btn_lat   <= btn_lat_d;
        end
    end

    logic [MAX_CH-1:0] show_mask;
    logic [NUM_CH-1:0] led_d;

    assign show_mask = onehot(3'(bus.seq_val));

    // LED decode: current sequence entry while showing, all lit on a win.
    always_comb begin
        led_d = '0;
        case (state)
            SHOW:    led_d = show_mask[NUM_CH-1:0];
            WIN:     led_d = '1;
            default: led_d = '0;
        endcase
    end

    assign bus.led       = led_d;
    assign bus.error_led = (state == ERROR);
    assign bus.win_led   = (state == WIN);
    assign bus.rd_addr   = rd_addr_q;
    assign bus.score     = score_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Self-checking bench for simon_game_ctrl (NUM_CH=4, MAX_LEN=4, TIMEOUT_TICKS=8).
// Expected LEDs, addresses and scores come from the game rules applied to the
// bench's copy of the sequence memory. Define SIMON_TIMEOUT_EN for the timeout build.
module tb_simon_game_ctrl;

    localparam int NUM_CH        = 4;
    localparam int MAX_LEN       = 4;
    localparam int TIMEOUT_TICKS = 8;

    logic       clk_tick = 1'b0;
    logic       reset;
    logic [1:0] mem [4];

    int n_total = 0;
    int n_pass  = 0;

    simon_game_ctrl_if #(.NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN)) bus ();

    simon_game_ctrl #(
        .NUM_CH        (NUM_CH),
        .MAX_LEN       (MAX_LEN),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .clk_tick (clk_tick),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk_tick = ~clk_tick;

    // Sequence memory: combinational read at the controller's address.
    assign bus.seq_val = mem[bus.rd_addr];

    function automatic logic [3:0] oh(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_tick);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_led, input logic e_err,
                             input logic e_win, input int e_score);
        check({tag, ".led"},   32'(bus.led),       32'(e_led));
        check({tag, ".err"},   32'(bus.error_led), 32'(e_err));
        check({tag, ".win"},   32'(bus.win_led),   32'(e_win));
        check({tag, ".score"}, 32'(bus.score),     32'(e_score));
    endtask

    // From IDLE: pulse start_play, expect first SHOW of round 1.
    task automatic start_game();
        bus.start_play = 1'b1;
        tick();
        bus.start_play = 1'b0;
        check_out("start", oh(mem[0]), 1'b0, 1'b0, 0);
        check("start.addr", 32'(bus.rd_addr), 32'd0);
    endtask

    // Expect SHOW/GAP pairs for round r, optionally with ignored input noise.
    task automatic show_phase(input int r, input bit noise);
        for (int i = 0; i < r; i++) begin
            check_out("show", oh(mem[i]), 1'b0, 1'b0, r - 1);
            check("show.addr", 32'(bus.rd_addr), 32'(i));
            bus.btn_valid  = noise;
            bus.btn_val    = 2'($urandom_range(0, 3));
            bus.start_play = noise;
            tick();
            bus.btn_valid  = 1'b0;
            bus.start_play = 1'b0;
            check_out("gap", 4'b0000, 1'b0, 1'b0, r - 1);
            bus.btn_valid  = noise;
            tick();
            bus.btn_valid  = 1'b0;
        end
        check_out("wait", 4'b0000, 1'b0, 1'b0, r - 1);
        check("wait.addr", 32'(bus.rd_addr), 32'd0);
    endtask

    // Enter round r's presses; position bad_pos (if >= 0) gets bad_val.
    // idle < 0 picks 0..3 idle ticks before each press.
    task automatic input_phase(input int r, input int bad_pos, input int bad_val,
                               input int idle, output bit erred);
        int n_idle;
        erred = 1'b0;
        for (int j = 0; j < r; j++) begin
            n_idle = (idle < 0) ? int'($urandom_range(0, 3)) : idle;
            for (int k = 0; k < n_idle; k++) begin
                tick();
                check_out("idle", 4'b0000, 1'b0, 1'b0, r - 1);
                check("idle.addr", 32'(bus.rd_addr), 32'(j));
            end
            bus.btn_valid = 1'b1;
            bus.btn_val   = (j == bad_pos) ? 2'(bad_val) : mem[j];
            tick();
            bus.btn_valid = 1'b0;
            check_out("check", 4'b0000, 1'b0, 1'b0, r - 1);
            tick();
            if (j == bad_pos) begin
                check_out("error", 4'b0000, 1'b1, 1'b0, r - 1);
                erred = 1'b1;
                return;
            end else if (j < r - 1) begin
                check_out("next", 4'b0000, 1'b0, 1'b0, r - 1);
                check("next.addr", 32'(bus.rd_addr), 32'(j + 1));
            end else if (r == MAX_LEN) begin
                check_out("win", 4'b1111, 1'b0, 1'b1, r);
            end else begin
                check_out("round", oh(mem[0]), 1'b0, 1'b0, r);
                check("round.addr", 32'(bus.rd_addr), 32'd0);
            end
        end
    endtask

    // From ERROR: any press restarts at round 1 with score cleared.
    task automatic recover();
        bus.btn_valid = 1'b1;
        bus.btn_val   = 2'($urandom_range(0, 3));
        tick();
        bus.btn_valid = 1'b0;
        check_out("recover", oh(mem[0]), 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_out("reset", 4'b0000, 1'b0, 1'b0, 0);
        check("reset.addr", 32'(bus.rd_addr), 32'd0);
    endtask

    initial begin
        bit erred;
        int err_round, err_pos, bad_val;

        reset          = 1'b1;
        bus.start_play = 1'b0;
        bus.btn_valid  = 1'b0;
        bus.btn_val    = 2'd0;
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;

        // Reset state, with other inputs asserted to show reset wins.
        bus.start_play = 1'b1;
        bus.btn_valid  = 1'b1;
        tick();
        bus.start_play = 1'b0;
        bus.btn_valid  = 1'b0;
        do_reset();

        // Presses in IDLE are ignored.
        bus.btn_valid = 1'b1;
        tick();
        bus.btn_valid = 1'b0;
        tick();
        check_out("idle_btn", 4'b0000, 1'b0, 1'b0, 0);

        // Full game to a win; noise presses during SHOW/GAP.
        start_game();
        for (int r = 1; r <= MAX_LEN; r++) begin
            show_phase(r, 1'b1);
            input_phase(r, -1, 0, 0, erred);
        end
        tick();
        check_out("win_hold", 4'b1111, 1'b0, 1'b1, 4);
        bus.btn_valid = 1'b1;
        tick();
        bus.btn_valid = 1'b0;
        check_out("win_exit", 4'b0000, 1'b0, 1'b0, 4);
        tick();
        check_out("idle_after_win", 4'b0000, 1'b0, 1'b0, 4);

        // Round 2: press 2 then 1 where 0 is expected.
        start_game();
        show_phase(1, 1'b0);
        input_phase(1, -1, 0, 0, erred);
        show_phase(2, 1'b0);
        input_phase(2, 1, 1, 0, erred);
        check("err.flag", 32'(erred), 32'd1);
        tick();
        check_out("err_hold", 4'b0000, 1'b1, 1'b0, 1);
        recover();
        check("recover.led", 32'(bus.led), 32'h4);

        // Idle player in WAIT.
        show_phase(1, 1'b0);
`ifdef SIMON_TIMEOUT_EN
        for (int k = 0; k < TIMEOUT_TICKS - 1; k++) begin
            tick();
            check_out("to_idle", 4'b0000, 1'b0, 1'b0, 0);
        end
        tick();
        check_out("timeout", 4'b0000, 1'b1, 1'b0, 0);
        recover();
        show_phase(1, 1'b0);
        input_phase(1, -1, 0, TIMEOUT_TICKS - 1, erred);
`else
        input_phase(1, -1, 0, 20, erred);
`endif

        // Reset during round 3 SHOW discards progress.
        show_phase(2, 1'b0);
        input_phase(2, -1, 0, -1, erred);
        reset         = 1'b1;
        bus.btn_valid = 1'b1;
        tick();
        reset         = 1'b0;
        bus.btn_valid = 1'b0;
        check_out("mid_reset", 4'b0000, 1'b0, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            bus.btn_valid = 1'b1;
            bus.btn_val   = mem[0];
            tick();
            bus.btn_valid = 1'b0;
            tick();
            check_out("post_reset", 4'b0000, 1'b0, 1'b0, 0);
        end
        start_game();

        // Randomized games: random memory, random mistakes and noise.
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < 4; i++) mem[i] = 2'($urandom_range(0, 3));
            do_reset();
            err_round = int'($urandom_range(0, MAX_LEN));
            err_pos   = (err_round > 0) ? int'($urandom_range(0, err_round - 1)) : -1;
            bad_val   = (err_pos >= 0) ? (int'(mem[err_pos]) + int'($urandom_range(1, 3))) % 4 : 0;
            start_game();
            erred = 1'b0;
            for (int r = 1; r <= MAX_LEN && !erred; r++) begin
                show_phase(r, 1'($urandom_range(0, 1)));
                input_phase(r, (r == err_round) ? err_pos : -1, bad_val, -1, erred);
            end
            if (erred) begin
                recover();
            end else begin
                bus.btn_valid = 1'b1;
                tick();
                bus.btn_valid = 1'b0;
                check_out("rnd_win_exit", 4'b0000, 1'b0, 1'b0, MAX_LEN);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Bound the run in case the sequence stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
